bcd_counter_7seg_mux: RTL and testbench

Parametrised N-digit decimal up/down counter with built-in 7-segment decode and time-multiplexed scan output. It generalises the single-digit 0-9 display counter:
- digit count, count rate and scan rate are configurable
- adds up/down counting, parallel load, leading-zero blanking and a one-hot digit-select output
- drives multiplexed or static multi-digit LED displays on the lab boards.

---
 rtl/bcd_counter_7seg_mux_if.sv | 28 ++
 rtl/bcd_counter_7seg_mux.sv | 207 ++++++++++++++++++++
 tb/tb_bcd_counter_7seg_mux.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_counter_7seg_mux_if.sv
// Bundle of the counter/display signals shared between the
// bcd_counter_7seg_mux block and whatever drives or observes it.
interface bcd_counter_7seg_mux_if #(
  parameter int NUM_DIGITS = 3
);
  logic                    en;
  logic                    up_dn;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic                    blank_lz;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [8*NUM_DIGITS-1:0] seg_all;
  logic [7:0]              scan_seg;
  logic [NUM_DIGITS-1:0]   scan_an;
  logic                    wrap;

  // Controller side: drives the controls and reads the display outputs.
  modport master (
    output en, up_dn, load, load_val, blank_lz,
    input  bcd_out, seg_all, scan_seg, scan_an, wrap
  );

  // Counter side: consumes the controls and drives the display outputs.
  modport slave (
    input  en, up_dn, load, load_val, blank_lz,
    output bcd_out, seg_all, scan_seg, scan_an, wrap
  );
endinterface

// File: rtl/bcd_counter_7seg_mux.sv
// N-digit BCD up/down counter with a prescaled count step, parallel load,
// registered 7-segment decode (optional leading-zero blanking) and a
// free-running multiplexed scan output.
module bcd_counter_7seg_mux #(
  parameter int NUM_DIGITS = 3,
  parameter int PRESCALE   = 10,
  parameter int SCAN_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_counter_7seg_mux_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int GW = 8 * NUM_DIGITS;

  // Segment pattern {a,b,c,d,e,f,g,dp}, active-high, dp never lit.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hE6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Non-decimal nibbles are not representable in the count; store them as 0.
  function automatic logic [3:0] digit_clean(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  logic [PW-1:0] presc_r, presc_nxt_s;
  logic [BW-1:0] bcd_r, bcd_nxt_s, inc_s, dec_s, load_clean_s;
  logic          inc_wrap_s, dec_wrap_s;
  logic          wrap_r, wrap_nxt_s;
  logic [GW-1:0] seg_all_r, seg_nxt_s;
  logic [SW-1:0] scan_cnt_r, scan_cnt_nxt_s;
  logic [IW-1:0] scan_idx_r, scan_idx_nxt_s;
  logic [7:0]    scan_seg_r, scan_seg_nxt_s;
  logic [NUM_DIGITS-1:0] scan_an_r, scan_an_nxt_s;

  // Ripple-carry increment, ripple-borrow decrement and load sanitising.
  always_comb begin
    logic       carry_v;
    logic       borrow_v;
    logic [3:0] d_v;
    inc_s        = '0;
    dec_s        = '0;
    load_clean_s = '0;
    carry_v      = 1'b1;
    borrow_v     = 1'b1;
    d_v          = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d_v = bcd_r[4*i +: 4];
      if (carry_v) begin
        if (d_v == 4'd9) begin
          inc_s[4*i +: 4] = 4'd0;
          carry_v         = 1'b1;
        end else begin
          inc_s[4*i +: 4] = d_v + 4'd1;
          carry_v         = 1'b0;
        end
      end else begin
        inc_s[4*i +: 4] = d_v;
      end
      if (borrow_v) begin
        if (d_v == 4'd0) begin
          dec_s[4*i +: 4] = 4'd9;
          borrow_v        = 1'b1;
        end else begin
          dec_s[4*i +: 4] = d_v - 4'd1;
          borrow_v        = 1'b0;
        end
      end else begin
        dec_s[4*i +: 4] = d_v;
      end
      load_clean_s[4*i +: 4] = digit_clean(bus.load_val[4*i +: 4]);
    end
    inc_wrap_s = carry_v;
    dec_wrap_s = borrow_v;
  end

  // Next count/prescaler state: load beats a tick, tick steps the count.
  always_comb begin
    bcd_nxt_s   = bcd_r;
    presc_nxt_s = presc_r;
    wrap_nxt_s  = 1'b0;
    if (bus.load) begin
      bcd_nxt_s   = load_clean_s;
      presc_nxt_s = '0;
    end else if (bus.en) begin
      if (presc_r == PRE_LAST) begin
        presc_nxt_s = '0;
        if (bus.up_dn) begin
          bcd_nxt_s  = inc_s;
          wrap_nxt_s = inc_wrap_s;
        end else begin
          bcd_nxt_s  = dec_s;
          wrap_nxt_s = dec_wrap_s;
        end
      end else begin
        presc_nxt_s = presc_r + PW'(1);
      end
    end else begin
      presc_nxt_s = presc_r;
    end
  end

  // Decode every digit, blanking zeros above the highest non-zero digit.
  always_comb begin
    logic       seen_v;
    logic [3:0] d_v;
    seg_nxt_s = '0;
    seen_v    = 1'b0;
    d_v       = 4'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      d_v = bcd_r[4*i +: 4];
      if (d_v != 4'd0) begin
        seen_v = 1'b1;
      end else begin
        seen_v = seen_v;
      end
      if (bus.blank_lz && !seen_v && (i != 0)) begin
        seg_nxt_s[8*i +: 8] = 8'h00;
      end else begin
        seg_nxt_s[8*i +: 8] = seg_decode(d_v);
      end
    end
  end

  // Scan divider and digit index; segment/anode outputs follow the new index.
  always_comb begin
    scan_cnt_nxt_s = scan_cnt_r;
    scan_idx_nxt_s = scan_idx_r;
    if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_nxt_s = '0;
      if (scan_idx_r == IDX_LAST) begin
        scan_idx_nxt_s = '0;
      end else begin
        scan_idx_nxt_s = scan_idx_r + IW'(1);
      end
    end else begin
      scan_cnt_nxt_s = scan_cnt_r + SW'(1);
    end
    scan_an_nxt_s  = NUM_DIGITS'(32'd1) << scan_idx_nxt_s;
    scan_seg_nxt_s = seg_all_r[{scan_idx_nxt_s, 3'b000} +: 8];
  end

  // Count, prescaler and wrap-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_r   <= '0;
      presc_r <= '0;
      wrap_r  <= 1'b0;
    end else begin
      bcd_r   <= bcd_nxt_s;
      presc_r <= presc_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  // Static per-digit segment register, one cycle behind the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_all_r <= {NUM_DIGITS{8'hFC}};
    end else begin
      seg_all_r <= seg_nxt_s;
    end
  end

  // Scan state; runs regardless of en and load.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r <= '0;
      scan_idx_r <= '0;
      scan_an_r  <= NUM_DIGITS'(32'd1);
      scan_seg_r <= 8'hFC;
    end else begin
      scan_cnt_r <= scan_cnt_nxt_s;
      scan_idx_r <= scan_idx_nxt_s;
      scan_an_r  <= scan_an_nxt_s;
      scan_seg_r <= scan_seg_nxt_s;
    end
  end

  assign bus.bcd_out  = bcd_r;
  assign bus.wrap     = wrap_r;
  assign bus.seg_all  = seg_all_r;
  assign bus.scan_seg = scan_seg_r;
  assign bus.scan_an  = scan_an_r;

endmodule

// File: tb/tb_bcd_counter_7seg_mux.sv
// Self-checking bench for bcd_counter_7seg_mux: a load/decode vector table,
// hand-written multi-cycle sequences and a randomized run, all checked
// against an integer-arithmetic model of the counter and display.
module tb_bcd_counter_7seg_mux;
  localparam int ND   = 3;
  localparam int PS   = 2;
  localparam int SD   = 4;
  localparam int MODV = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_counter_7seg_mux_if #(.NUM_DIGITS(ND)) bus ();

  bcd_counter_7seg_mux #(.NUM_DIGITS(ND), .PRESCALE(PS), .SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: count as a plain integer, cycle counts for timing.
  int         m_cnt, m_pre, m_scan_cyc;
  bit         m_wrap;
  logic [7:0] m_seg [ND];
  logic [7:0] m_scan_seg;
  logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                               8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};

  typedef struct {
    logic [11:0] lv;
    logic        blz;
    logic [11:0] exp_bcd;
    logic [23:0] exp_seg;
  } vec_t;
  vec_t vecs [10];

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic int clean_val(input logic [11:0] v);
    int s = 0;
    for (int k = 0; k < ND; k++) begin
      int d = int'(v[4*k +: 4]);
      if (d > 9) d = 0;
      s = s + d * pow10(k);
    end
    return s;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r = '0;
    for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees.
  task automatic model_edge();
    logic [7:0] old_seg [ND];
    old_seg = m_seg;
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_wrap = 0; m_scan_cyc = 0; m_scan_seg = 8'hFC;
      for (int k = 0; k < ND; k++) m_seg[k] = 8'hFC;
    end else begin
      m_scan_cyc++;
      m_scan_seg = old_seg[(m_scan_cyc / SD) % ND];
      for (int k = 0; k < ND; k++) begin
        if (bus.blank_lz && k > 0 && m_cnt < pow10(k)) m_seg[k] = 8'h00;
        else m_seg[k] = seg_tab[(m_cnt / pow10(k)) % 10];
      end
      if (bus.load) begin
        m_cnt = clean_val(bus.load_val); m_pre = 0; m_wrap = 0;
      end else if (bus.en) begin
        if (m_pre == PS - 1) begin
          m_pre = 0;
          if (bus.up_dn) begin
            m_wrap = (m_cnt == MODV - 1); m_cnt = (m_cnt + 1) % MODV;
          end else begin
            m_wrap = (m_cnt == 0); m_cnt = (m_cnt + MODV - 1) % MODV;
          end
        end else begin
          m_pre++; m_wrap = 0;
        end
      end else begin
        m_wrap = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [23:0] es;
    for (int k = 0; k < ND; k++) es[8*k +: 8] = m_seg[k];
    check("model_bcd", 32'(bus.bcd_out), 32'(to_bcd(m_cnt)));
    check("model_wrap", 32'(bus.wrap), 32'(m_wrap));
    check("model_seg_all", 32'(bus.seg_all), 32'(es));
    check("model_scan_seg", 32'(bus.scan_seg), 32'(m_scan_seg));
    check("model_scan_an", 32'(bus.scan_an), 32'(1 << ((m_scan_cyc / SD) % ND)));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive(input logic e, input logic u, input logic l,
                       input logic [11:0] lv, input logic b);
    bus.en = e; bus.up_dn = u; bus.load = l; bus.load_val = lv; bus.blank_lz = b;
  endtask

  initial begin
    int         wc;
    logic [11:0] bw;
    vecs[0] = '{12'h998, 1'b0, 12'h998, 24'hE6E6FE};
    vecs[1] = '{12'h0AF, 1'b0, 12'h000, 24'hFCFCFC};
    vecs[2] = '{12'h007, 1'b1, 12'h007, 24'h0000E0};
    vecs[3] = '{12'h000, 1'b1, 12'h000, 24'h0000FC};
    vecs[4] = '{12'h000, 1'b0, 12'h000, 24'hFCFCFC};
    vecs[5] = '{12'h123, 1'b0, 12'h123, 24'h60DAF2};
    vecs[6] = '{12'h9A9, 1'b0, 12'h909, 24'hE6FCE6};
    vecs[7] = '{12'h100, 1'b1, 12'h100, 24'h60FCFC};
    vecs[8] = '{12'h050, 1'b1, 12'h050, 24'h00B6FC};
    vecs[9] = '{12'h456, 1'b1, 12'h456, 24'h66B6BE};

    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    cyc(); cyc();
    check("rst_bcd", 32'(bus.bcd_out), 32'h0);
    check("rst_seg_all", 32'(bus.seg_all), 32'hFCFCFC);
    check("rst_scan_an", 32'(bus.scan_an), 32'h1);
    check("rst_scan_seg", 32'(bus.scan_seg), 32'hFC);
    check("rst_wrap", 32'(bus.wrap), 32'h0);

    // Up-count from zero: 20 enabled cycles at PRESCALE=2 give 10 steps.
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    repeat (20) cyc();
    check("up20_bcd", 32'(bus.bcd_out), 32'h010);
    bus.en = 1'b0;
    cyc();
    check("up20_seg", 32'(bus.seg_all), 32'hFC60FC);

    // Load/decode table.
    foreach (vecs[v]) begin
      drive(1'b0, 1'b1, 1'b1, vecs[v].lv, vecs[v].blz);
      cyc();
      bus.load = 1'b0;
      check($sformatf("vec%0d_bcd", v), 32'(bus.bcd_out), 32'(vecs[v].exp_bcd));
      cyc();
      check($sformatf("vec%0d_seg", v), 32'(bus.seg_all), 32'(vecs[v].exp_seg));
    end

    // 998 up through 999 to 000: exactly one wrap, in the 000 cycle.
    drive(1'b0, 1'b1, 1'b1, 12'h998, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    wc = 0; bw = 12'hFFF;
    repeat (6) begin
      cyc();
      if (bus.wrap) begin wc++; bw = bus.bcd_out; end
    end
    check("upwrap_count", 32'(wc), 32'd1);
    check("upwrap_bcd", 32'(bw), 32'h000);

    // Down from 000 wraps to 999; 100 down borrows to 099 without wrap.
    drive(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
    cyc();
    bus.load = 1'b0; bus.en = 1'b1;
    cyc(); cyc();
    check("dnwrap_bcd", 32'(bus.bcd_out), 32'h999);
    check("dnwrap_wrap", 32'(bus.wrap), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 12'h100, 1'b0);
    cyc();
    bus.load = 1'b0; bus.en = 1'b1;
    cyc(); cyc();
    check("borrow_bcd", 32'(bus.bcd_out), 32'h099);
    check("borrow_wrap", 32'(bus.wrap), 32'h0);

    // Load coincident with a tick: load wins and restarts the prescaler.
    drive(1'b0, 1'b1, 1'b1, 12'h123, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 1'b1, 12'h456, 1'b0);
    cyc();
    check("ldtick_bcd", 32'(bus.bcd_out), 32'h456);
    check("ldtick_wrap", 32'(bus.wrap), 32'h0);
    bus.load = 1'b0;
    cyc();
    check("ldtick_hold", 32'(bus.bcd_out), 32'h456);

    // Scan sequence from reset with 123 displayed.
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
    cyc();
    rst = 1'b0;
    check("scan_k0", 32'(bus.scan_an), 32'h1);
    bus.load = 1'b1; bus.load_val = 12'h123;
    cyc();
    bus.load = 1'b0;
    cyc(); cyc();
    check("scan_k3", 32'(bus.scan_an), 32'h1);
    cyc();
    check("scan_k4_an", 32'(bus.scan_an), 32'h2);
    check("scan_k4_seg", 32'(bus.scan_seg), 32'hDA);
    check("scan_k4_slice", 32'(bus.scan_seg), 32'(bus.seg_all[15:8]));
    repeat (4) cyc();
    check("scan_k8_an", 32'(bus.scan_an), 32'h4);
    check("scan_k8_seg", 32'(bus.scan_seg), 32'h60);
    repeat (4) cyc();
    check("scan_k12_an", 32'(bus.scan_an), 32'h1);
    check("scan_k12_seg", 32'(bus.scan_seg), 32'hF2);

    // Reset mid-scan, on the edge where a wrapping tick would occur.
    drive(1'b0, 1'b1, 1'b1, 12'h999, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    check("rstmid_an", 32'(bus.scan_an), 32'h1);
    check("rstmid_seg", 32'(bus.scan_seg), 32'hFC);
    check("rstmid_bcd", 32'(bus.bcd_out), 32'h0);
    check("rstmid_wrap", 32'(bus.wrap), 32'h0);
    rst = 1'b0;

    // Randomized run against the model.
    for (int n = 0; n < 800; n++) begin
      rst          = ($urandom_range(0, 149) == 0);
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.up_dn    = ($urandom_range(0, 2) != 0);
      bus.load     = ($urandom_range(0, 24) == 0);
      bus.load_val = 12'($urandom);
      if ($urandom_range(0, 39) == 0) bus.blank_lz = ~bus.blank_lz;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
